// File: rtl/pc_fetch.sv
// ============================================================================
//  Module   : pc_fetch
//  Brief    : Instruction fetch stage with stall holding and branch redirect.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_bj,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_req_addr;
  logic [31:0] r_target;
  logic [31:0] r_hold_instr;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_flush;

  logic        w_deliver;
  logic        w_capture;
  logic [31:0] w_dl_instr;
  logic [31:0] w_req_addr_nxt;
  logic [31:0] w_target_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (pc_bj)                 w_state_nxt = imem_ack ? S_FETCH : S_DISCARD;
        else if (imem_ack && stall) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (pc_bj || !stall) w_state_nxt = S_FETCH;
      end
      S_DISCARD: begin
        if (imem_ack) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // In HOLD the request address still names the held word, so it doubles as its PC.
  always_comb begin
    w_deliver      = 1'b0;
    w_capture      = 1'b0;
    w_dl_instr     = imem_rdata;
    w_req_addr_nxt = r_req_addr;
    w_target_nxt   = r_target;
    case (r_state)
      S_FETCH: begin
        if (pc_bj) begin
          if (imem_ack) w_req_addr_nxt = target;
          else          w_target_nxt   = target;
        end else if (imem_ack) begin
          if (stall) begin
            w_capture = 1'b1;
          end else begin
            w_deliver      = 1'b1;
            w_req_addr_nxt = r_req_addr + 32'd1;
          end
        end
      end
      S_HOLD: begin
        if (pc_bj) begin
          w_req_addr_nxt = target;
        end else if (!stall) begin
          w_deliver      = 1'b1;
          w_dl_instr     = r_hold_instr;
          w_req_addr_nxt = r_req_addr + 32'd1;
        end
      end
      S_DISCARD: begin
        if (pc_bj) begin
          if (imem_ack) w_req_addr_nxt = target;
          else          w_target_nxt   = target;
        end else if (imem_ack) begin
          w_req_addr_nxt = r_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_addr   <= RESET_PC;
      r_target     <= RESET_PC;
      r_hold_instr <= 32'd0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'd0;
      r_if_pc      <= 32'd0;
      r_flush      <= 1'b0;
    end else begin
      r_req_addr <= w_req_addr_nxt;
      r_target   <= w_target_nxt;
      r_if_valid <= w_deliver;
      r_flush    <= pc_bj;
      if (w_capture) r_hold_instr <= imem_rdata;
      if (w_deliver) begin
        r_if_instr <= w_dl_instr;
        r_if_pc    <= r_req_addr;
      end
    end
  end

  assign imem_req  = !rst && (r_state != S_HOLD);
  assign imem_addr = r_req_addr;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign flush     = r_flush;

endmodule

`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the word address fetched first after reset.
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-005 SHALL have pc_bj  input  1  redirect request from the next-PC select logic.
REQ-006 SHALL have target  input  32  redirect word address, valid when pc_bj=1.
REQ-007 SHALL have imem_req  output  1  instruction memory request.
REQ-008 SHALL have imem_addr  output  32  word address of the current request.
REQ-009 SHALL have imem_ack  input  1  memory returns data this cycle; may coincide with the request cycle.
REQ-010 SHALL have imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-011 SHALL have if_valid  output  1  one-cycle pulse: if_instr/if_pc carry a delivered instruction.
REQ-012 SHALL have if_instr  output  32  delivered instruction word.
REQ-013 SHALL have if_pc  output  32  word address of if_instr; feeds the next-PC select logic's current-PC input.
REQ-014 SHALL have flush  output  1  one-cycle pulse telling the decode register to discard its contents.

Function
REQ-015 SHALL use word addressing: sequential next PC = pc+1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-016 SHALL implement states FETCH (request outstanding), HOLD (word captured, waiting on stall) and DISCARD (outstanding request is stale).
REQ-017 SHALL drive imem_req=1 in FETCH and DISCARD and 0 in HOLD, and SHALL force it to 0 while rst=1.
REQ-018 SHALL keep imem_addr stable from request assertion until the acknowledging cycle, using a dedicated request-address register.
REQ-019 FETCH, imem_ack=1, pc_bj=0, stall=0: SHALL register if_valid=1, if_instr=imem_rdata and if_pc=imem_addr for the next cycle, then request imem_addr+1 from the next cycle on (throughput one per cycle).
REQ-020 FETCH, imem_ack=1, pc_bj=0, stall=1: SHALL capture the word and its address, go to HOLD and keep if_valid=0.
REQ-021 HOLD, stall=0, pc_bj=0: SHALL pulse if_valid with the held word on the next cycle and return to FETCH at held address+1.
REQ-022 pc_bj=1 in any state SHALL take priority over stall and ack, load PC with target, and pulse flush=1 on the next cycle.
REQ-023 Redirect in FETCH with imem_ack=1 in the same cycle, or redirect in HOLD: SHALL drop the word (no if_valid) and go to FETCH at target.
REQ-024 Redirect in FETCH with imem_ack=0: SHALL go to DISCARD, keeping req/addr of the stale request.
REQ-025 DISCARD: SHALL drop returned data on imem_ack and move to FETCH at the stored target; a further pc_bj updates the target, pulses flush and remains in DISCARD (or moves to FETCH if ack is also 1).
REQ-026 if_valid and flush SHALL never be 1 in the same cycle.
REQ-027 SHALL hold if_instr and if_pc unchanged in cycles where if_valid=0.

Reset
REQ-028 While rst=1: state=FETCH, PC and request address=RESET_PC, if_valid=0, flush=0, if_instr=0, if_pc=0, imem_req=0; imem_ack is ignored.
REQ-029 rst asserted mid-request SHALL abandon the request without delivering its data; the first request after rst falls is to RESET_PC.

Verification
REQ-030 Reset, memory acks the same cycle, stall=0 -> if_pc 0,1,2,3 on consecutive cycles with if_valid=1 each cycle, flush=0.
REQ-031 Ack at PC 5 with stall=1 held 3 cycles -> imem_req=0 for those 3 cycles; one cycle after stall falls, if_valid=1, if_pc=5, and the next request is to 6.
REQ-032 Memory with 3-cycle latency, pc_bj=1, target=0x40 one cycle after the request to 8 -> flush pulses once, ack for 8 produces no if_valid, next request is to 0x40.
REQ-033 pc_bj=1, target=0x10 with stall=1 and imem_ack=1 in the same cycle -> data dropped, flush=1 next cycle, next request is to 0x10.
REQ-034 RESET_PC=32'hFFFF_FFFF -> if_pc FFFF_FFFF then 0 on consecutive deliveries.
REQ-035 rst asserted during DISCARD with a late ack -> no if_valid, no flush, first request after reset is to RESET_PC.
